// File: rtl/sw_job_scheduler_if.sv
// Request/result handshake bundle for sw_job_scheduler.
// master = requesters and result consumer, slave = the scheduler.
interface sw_job_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int REF_LEN    = 15,
  parameter int QUERY_LEN  = 10,
  parameter int BASE_WIDTH = 2,
  parameter int ALIGN_LEN  = REF_LEN + QUERY_LEN,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                       req_valid;
  logic [NUM_REQ-1:0]                       req_ready;
  logic [NUM_REQ*REF_LEN*BASE_WIDTH-1:0]    req_ref_seq;
  logic [NUM_REQ*QUERY_LEN*BASE_WIDTH-1:0]  req_query_seq;
  logic                                     res_valid;
  logic                                     res_ready;
  logic [ID_W-1:0]                          res_id;
  logic [ALIGN_LEN*BASE_WIDTH-1:0]          res_aligned_ref_seq;
  logic [ALIGN_LEN*BASE_WIDTH-1:0]          res_aligned_query_seq;
  logic [7:0]                               res_length;

  modport master (
    output req_valid, req_ref_seq, req_query_seq, res_ready,
    input  req_ready, res_valid, res_id, res_aligned_ref_seq,
           res_aligned_query_seq, res_length
  );

  modport slave (
    input  req_valid, req_ref_seq, req_query_seq, res_ready,
    output req_ready, res_valid, res_id, res_aligned_ref_seq,
           res_aligned_query_seq, res_length
  );
endinterface

// File: rtl/sw_job_scheduler.sv
// Round-robin job scheduler for one shared smith_waterman core: loads a job,
// pulses the core reset, waits a fixed compute window, then returns the result.
module sw_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int REF_LEN        = 15,
  parameter int QUERY_LEN      = 10,
  parameter int BASE_WIDTH     = 2,
  parameter int ALIGN_LEN      = REF_LEN + QUERY_LEN,
  parameter int RST_CYCLES     = 2,
  parameter int COMPUTE_CYCLES = 20,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  sw_job_scheduler_if.slave                 bus,
  output logic                              sw_rst,
  output logic [REF_LEN*BASE_WIDTH-1:0]     sw_ref_seq,
  output logic [QUERY_LEN*BASE_WIDTH-1:0]   sw_query_seq,
  input  logic [ALIGN_LEN*BASE_WIDTH-1:0]   sw_aligned_ref_seq,
  input  logic [ALIGN_LEN*BASE_WIDTH-1:0]   sw_aligned_query_seq,
  input  logic [7:0]                        sw_alignment_length,
  output logic                              busy
);
  localparam int RW      = REF_LEN * BASE_WIDTH;
  localparam int QW      = QUERY_LEN * BASE_WIDTH;
  localparam int AW      = ALIGN_LEN * BASE_WIDTH;
  localparam int CNT_MAX = (RST_CYCLES > COMPUTE_CYCLES) ? RST_CYCLES : COMPUTE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   job_id_q, job_id_d;
  logic [RW-1:0]     sw_ref_q, sw_ref_d;
  logic [QW-1:0]     sw_query_q, sw_query_d;
  logic              res_valid_q, res_valid_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [AW-1:0]     res_ref_q, res_ref_d;
  logic [AW-1:0]     res_query_q, res_query_d;
  logic [7:0]        res_len_q, res_len_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] req_ready_o;

  function automatic logic [ID_W-1:0] rot(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && bus.req_valid[rot(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rot(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    job_id_d    = job_id_q;
    sw_ref_d    = sw_ref_q;
    sw_query_d  = sw_query_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_ref_d   = res_ref_q;
    res_query_d = res_query_q;
    res_len_d   = res_len_q;
    unique case (state_q)
      IDLE: if (grant_found) begin
        sw_ref_d   = bus.req_ref_seq[int'(grant_idx)*RW +: RW];
        sw_query_d = bus.req_query_seq[int'(grant_idx)*QW +: QW];
        job_id_d   = grant_idx;
        rr_ptr_d   = rot(grant_idx, 1);
        cnt_d      = CNT_W'(RST_CYCLES - 1);
        state_d    = CLEAR;
      end
      CLEAR: if (cnt_q == '0) begin
        cnt_d   = CNT_W'(COMPUTE_CYCLES - 1);
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      RUN: if (cnt_q == '0) begin
        res_ref_d   = sw_aligned_ref_seq;
        res_query_d = sw_aligned_query_seq;
        res_len_d   = sw_alignment_length;
        res_id_d    = job_id_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      DONE: if (bus.res_ready) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      job_id_q    <= '0;
      sw_ref_q    <= '0;
      sw_query_q  <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_ref_q   <= '0;
      res_query_q <= '0;
      res_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      job_id_q    <= job_id_d;
      sw_ref_q    <= sw_ref_d;
      sw_query_q  <= sw_query_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_ref_q   <= res_ref_d;
      res_query_q <= res_query_d;
      res_len_q   <= res_len_d;
    end
  end

  // Grant is combinational but suppressed while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && grant_found && !rst) req_ready_o[grant_idx] = 1'b1;
  end

  assign bus.req_ready             = req_ready_o;
  assign bus.res_valid             = res_valid_q;
  assign bus.res_id                = res_id_q;
  assign bus.res_aligned_ref_seq   = res_ref_q;
  assign bus.res_aligned_query_seq = res_query_q;
  assign bus.res_length            = res_len_q;
  assign sw_rst                    = (state_q != RUN);
  assign sw_ref_seq                = sw_ref_q;
  assign sw_query_seq              = sw_query_q;
  assign busy                      = (state_q != IDLE);
endmodule

// File: tb/tb_sw_job_scheduler.sv
// Scoreboard bench for sw_job_scheduler: random requesters, a stub core whose
// outputs depend on the loaded job and the cycles since its reset fell.
module tb_sw_job_scheduler;
  localparam int N  = 4;
  localparam int R  = 15;
  localparam int Q  = 10;
  localparam int B  = 2;
  localparam int AL = R + Q;
  localparam int RC = 2;
  localparam int CC = 20;
  localparam int IW = 2;
  localparam int RW = R * B;
  localparam int QW = Q * B;
  localparam int AW = AL * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sw_job_scheduler_if #(.NUM_REQ(N), .REF_LEN(R), .QUERY_LEN(Q), .BASE_WIDTH(B)) bus ();
  sw_job_scheduler_if #(.NUM_REQ(N), .REF_LEN(R), .QUERY_LEN(Q), .BASE_WIDTH(B)) bus2 ();

  logic          sw_rst, busy, sw_rst2, busy2;
  logic [RW-1:0] sw_ref, sw_ref2;
  logic [QW-1:0] sw_query, sw_query2;
  logic [AW-1:0] c_ar, c_aq, c2_ar, c2_aq;
  logic [7:0]    c_len, c2_len;

  sw_job_scheduler #(.NUM_REQ(N), .REF_LEN(R), .QUERY_LEN(Q), .BASE_WIDTH(B),
                     .RST_CYCLES(RC), .COMPUTE_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sw_rst(sw_rst), .sw_ref_seq(sw_ref),
    .sw_query_seq(sw_query), .sw_aligned_ref_seq(c_ar), .sw_aligned_query_seq(c_aq),
    .sw_alignment_length(c_len), .busy(busy));

  sw_job_scheduler #(.NUM_REQ(N), .REF_LEN(R), .QUERY_LEN(Q), .BASE_WIDTH(B),
                     .RST_CYCLES(1), .COMPUTE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .sw_rst(sw_rst2), .sw_ref_seq(sw_ref2),
    .sw_query_seq(sw_query2), .sw_aligned_ref_seq(c2_ar), .sw_aligned_query_seq(c2_aq),
    .sw_alignment_length(c2_len), .busy(busy2));

  // Stub core: output is a function of the loaded job and cycles since sw_rst fell.
  int run_cnt = 0;
  always @(posedge clk) run_cnt <= sw_rst ? 0 : run_cnt + 1;

  function automatic logic [AW-1:0] mix_ar(input logic [RW-1:0] r, input logic [QW-1:0] q, input int n);
    return {q, r} ^ AW'(64'(n) * 64'h9E3779B97F4A7C15);
  endfunction
  function automatic logic [AW-1:0] mix_aq(input logic [RW-1:0] r, input logic [QW-1:0] q, input int n);
    return {r, q} + AW'(n);
  endfunction
  function automatic logic [7:0] mix_len(input logic [QW-1:0] q, input int n);
    return q[7:0] ^ 8'(n * 37);
  endfunction

  assign c_ar   = mix_ar(sw_ref, sw_query, run_cnt);
  assign c_aq   = mix_aq(sw_ref, sw_query, run_cnt);
  assign c_len  = mix_len(sw_query, run_cnt);
  assign c2_ar  = {sw_query2, sw_ref2};
  assign c2_aq  = ~{sw_ref2, sw_query2};
  assign c2_len = 8'hFF;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] ar;
    logic [AW-1:0] aq;
    logic [7:0]    len;
    int            t;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [N-1:0]  vld = '0;
  logic [N-1:0]  keep = '0;
  logic [RW-1:0] rref[N];
  logic [QW-1:0] rq[N];
  int unsigned   p_new = 0;
  int unsigned   p_rdy = 100;
  int            mptr = 0;
  bit            in_flight = 1'b0;
  int            low_cnt = 0;
  bit            acc_now = 1'b0;
  int            acc_id = 0;
  int            last_id = 0;
  logic [RW-1:0] last_ref;
  logic [QW-1:0] last_q;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] enc(input string s);
    logic [63:0] v = '0;
    for (int k = 0; k < s.len(); k++)
      case (s[k])
        "T":     v[2*k +: 2] = 2'b01;
        "G":     v[2*k +: 2] = 2'b10;
        "C":     v[2*k +: 2] = 2'b11;
        default: v[2*k +: 2] = 2'b00;
      endcase
    return v;
  endfunction

  task automatic drive();
    bus.req_valid = vld;
    for (int i = 0; i < N; i++) begin
      bus.req_ref_seq[i*RW +: RW]   = rref[i];
      bus.req_query_seq[i*QW +: QW] = rq[i];
    end
  endtask

  // One clock: model check at negedge, new stimulus just after posedge.
  task automatic cycle();
    logic [N-1:0]  exp_rdy;
    logic [RW-1:0] r;
    logic [QW-1:0] q;
    int            g;
    exp_t          e;
    @(negedge clk);
    if (!rst) begin
      chk("busy", 64'(busy), 64'(in_flight));
      if (!sw_rst) low_cnt++;
      if (!in_flight) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.req_valid[(mptr + k) % N]) g = (mptr + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready_grant", 64'(bus.req_ready), 64'(exp_rdy));
        if (g >= 0) begin
          r = bus.req_ref_seq[g*RW +: RW];
          q = bus.req_query_seq[g*QW +: QW];
          e.id = IW'(g); e.ar = mix_ar(r, q, CC - 1); e.aq = mix_aq(r, q, CC - 1);
          e.len = mix_len(q, CC - 1); e.t = cyc;
          sb.push_back(e);
          grant_log.push_back(g);
          mptr = (g + 1) % N; in_flight = 1'b1; low_cnt = 0;
          acc_now = 1'b1; acc_id = g; last_id = g; last_ref = r; last_q = q;
        end
      end else begin
        chk("req_ready_held", 64'(bus.req_ready), 64'(0));
        if (bus.res_valid && bus.res_ready) in_flight = 1'b0;
      end
    end
    @(posedge clk); #1;
    if (acc_now) begin vld[acc_id] = 1'b0; acc_now = 1'b0; end
    for (int i = 0; i < N; i++)
      if (!vld[i] && (keep[i] || $urandom_range(99) < p_new)) begin
        vld[i] = 1'b1; rref[i] = RW'($urandom()); rq[i] = QW'($urandom());
      end
    bus.res_ready = ($urandom_range(99) < p_rdy);
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_grants(input int n, input int bound);
    for (int k = 0; k < bound && grant_log.size() < n; k++) cycle();
    chk("grants_reached", 64'(grant_log.size()), 64'(n));
  endtask

  // Called just after a posedge; asserts reset asynchronously.
  task automatic do_reset(input bit reissue);
    rst = 1'b1; #1;
    chk("rst_sw_rst", 64'(sw_rst), 64'(1));
    chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    sb.delete(); in_flight = 1'b0; mptr = 0; low_cnt = 0; acc_now = 1'b0;
    keep = '0; p_new = 0; vld = '0;
    if (reissue) begin vld[last_id] = 1'b1; rref[last_id] = last_ref; rq[last_id] = last_q; end
    drive();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    grant_log.delete();
  endtask

  // Monitor: compares any presented result against the scoreboard head.
  bit prev_rv = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_rv = 1'b0;
    else begin
      if (bus.res_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: res_id %0d with empty scoreboard", bus.res_id);
        end else begin
          chk("res_id", 64'(bus.res_id), 64'(sb[0].id));
          chk("res_aligned_ref", 64'(bus.res_aligned_ref_seq), 64'(sb[0].ar));
          chk("res_aligned_query", 64'(bus.res_aligned_query_seq), 64'(sb[0].aq));
          chk("res_length", 64'(bus.res_length), 64'(sb[0].len));
          if (!prev_rv) begin
            chk("latency", 64'(cyc), 64'(sb[0].t + 1 + RC + CC));
            chk("sw_rst_low_cycles", 64'(low_cnt), 64'(CC));
          end
          if (bus.res_ready) void'(sb.pop_front());
        end
      end
      prev_rv = bus.res_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int exp_fair[3] = '{2, 1, 2};
  int t0, got, lows;

  initial begin
    for (int i = 0; i < N; i++) begin rref[i] = RW'($urandom()); rq[i] = QW'($urandom()); end
    vld = '1; drive(); bus.res_ready = 1'b1;
    bus2.req_valid = '0; bus2.req_ref_seq = '0; bus2.req_query_seq = '0; bus2.res_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_sw_rst", 64'(sw_rst), 64'(1));
    chk("reset_sw_ref", 64'(sw_ref), 64'(0));
    chk("reset_sw_query", 64'(sw_query), 64'(0));
    chk("reset_res_valid", 64'(bus.res_valid), 64'(0));
    chk("reset_res_id", 64'(bus.res_id), 64'(0));
    chk("reset_res_length", 64'(bus.res_length), 64'(0));
    chk("reset_res_ref", 64'(bus.res_aligned_ref_seq), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_req_ready", 64'(bus.req_ready), 64'(0));
    vld = '0; drive(); rst = 1'b0;

    // Single job with a known sequence.
    p_rdy = 100;
    rref[0] = RW'(enc("ACGTACGTACGTACG")); rq[0] = QW'(enc("ACGTACGTAC"));
    vld[0] = 1'b1; drive();
    wait_grants(1, 10);
    chk("t1_sw_ref_loaded", 64'(sw_ref), enc("ACGTACGTACGTACG"));
    chk("t1_grant", 64'(grant_log[0]), 64'(0));
    run(30);

    // Round-robin with all requesters held.
    do_reset(1'b0);
    keep = '1; vld = '1; drive();
    wait_grants(5, 200);
    keep = '0;
    for (int i = 0; i < 5; i++) chk("t2_rr_order", 64'(grant_log[i]), 64'(exp_rr[i]));
    run(30);

    // Back-pressure: result held 10 cycles.
    do_reset(1'b0);
    p_rdy = 0; vld[1] = 1'b1; vld[2] = 1'b1; drive();
    for (int k = 0; k < 60 && !bus.res_valid; k++) cycle();
    chk("t3_res_seen", 64'(bus.res_valid), 64'(1));
    run(10);
    p_rdy = 100;
    run(40);
    chk("t3_grants", 64'(grant_log.size()), 64'(2));

    // Reset five cycles into compute, then reissue.
    do_reset(1'b0);
    vld[3] = 1'b1; drive();
    wait_grants(1, 10);
    run(RC + 5);
    do_reset(1'b1);
    wait_grants(1, 10);
    chk("t4_reissue_id", 64'(grant_log[0]), 64'(3));
    run(30);

    // Fairness: requester 2 continuous, requester 1 joins after first grant.
    do_reset(1'b0);
    keep[2] = 1'b1; vld[2] = 1'b1; drive();
    wait_grants(1, 10);
    vld[1] = 1'b1; rref[1] = RW'($urandom()); rq[1] = QW'($urandom()); drive();
    wait_grants(3, 100);
    keep = '0;
    for (int i = 0; i < 3; i++) chk("t5_fair_order", 64'(grant_log[i]), 64'(exp_fair[i]));
    run(30);

    // Random traffic with random back-pressure, then drain.
    do_reset(1'b0);
    p_new = 30; p_rdy = 70;
    run(800);
    p_new = 0;
    for (int k = 0; k < 600 && (sb.size() > 0 || bus.req_valid != '0 || in_flight); k++) cycle();
    chk("drain_scoreboard_empty", 64'(sb.size()), 64'(0));

    // Minimal-window instance: RST_CYCLES=1, COMPUTE_CYCLES=1.
    @(posedge clk); #1;
    bus2.req_ref_seq[3*RW +: RW] = RW'($urandom());
    bus2.req_query_seq[3*QW +: QW] = QW'($urandom());
    bus2.req_valid = 4'b1000;
    @(negedge clk);
    chk("p6_grant", 64'(bus2.req_ready), 64'(4'b1000));
    t0 = cyc;
    @(posedge clk); #1;
    bus2.req_valid = '0;
    got = -1; lows = 0;
    for (int k = 0; k < 10 && got < 0; k++) begin
      @(negedge clk);
      if (!sw_rst2) lows++;
      if (bus2.res_valid) got = cyc;
    end
    chk("p6_latency", 64'(got), 64'(t0 + 3));
    chk("p6_sw_rst_low", 64'(lows), 64'(1));
    chk("p6_res_id", 64'(bus2.res_id), 64'(3));
    chk("p6_res_ref", 64'(bus2.res_aligned_ref_seq),
        64'({bus2.req_query_seq[3*QW +: QW], bus2.req_ref_seq[3*RW +: RW]}));
    chk("p6_len_passthrough", 64'(bus2.res_length), 64'(8'hFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sw_job_scheduler.md
Name: sw_job_scheduler

Overview:
- Shares one smith_waterman alignment core between NUM_REQ requesters, such as per-read fetch engines.
- Arbitrates jobs round-robin over a valid/ready interface and loads the job's reference and query into the core.
- Sequences the core's reset and a fixed compute window, since the core has no start/done signals.
- Captures the aligned outputs and returns them, tagged with the requester ID, over a valid/ready result port.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
REF_LEN, 15, reference bases per job
QUERY_LEN, 10, query bases per job
BASE_WIDTH, 2, bits per base (A=00, T=01, G=10, C=11)
ALIGN_LEN, REF_LEN+QUERY_LEN, max aligned length in bases
RST_CYCLES, 2, cycles sw_rst is held high after each load (>=1)
COMPUTE_CYCLES, 20, cycles the core runs before capture (>=1)
ID_W, $clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  job request per requester
req_ready  out  NUM_REQ  one-hot grant/accept; combinational in IDLE only
req_ref_seq  in  NUM_REQ*REF_LEN*BASE_WIDTH  packed refs; requester i at slice i
req_query_seq  in  NUM_REQ*QUERY_LEN*BASE_WIDTH  packed queries; requester i at slice i
sw_rst  out  1  drives core rst
sw_ref_seq  out  REF_LEN*BASE_WIDTH  registered reference to core
sw_query_seq  out  QUERY_LEN*BASE_WIDTH  registered query to core
sw_aligned_ref_seq  in  ALIGN_LEN*BASE_WIDTH  core output
sw_aligned_query_seq  in  ALIGN_LEN*BASE_WIDTH  core output
sw_alignment_length  in  8  core output
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_id  out  ID_W  requester that owns the result
res_aligned_ref_seq  out  ALIGN_LEN*BASE_WIDTH  captured aligned reference
res_aligned_query_seq  out  ALIGN_LEN*BASE_WIDTH  captured aligned query
res_length  out  8  captured alignment length
busy  out  1  high whenever state != IDLE

Behaviour:
- **FSM states:** IDLE, CLEAR, RUN, DONE.
- **Reset (async, rst=1):**
  - state=IDLE, rr_ptr=0, counter=0.
  - sw_rst=1; sw_ref_seq, sw_query_seq, res_* and res_valid = 0.
  - busy=0, req_ready=0.
- **IDLE:**
  - Grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=1 in the same cycle; all other req_ready bits are 0.
  - On that edge: latch the granted slices into sw_ref_seq and sw_query_seq, latch grant into a job_id register, set rr_ptr=(grant+1) mod NUM_REQ, set counter=RST_CYCLES-1, go to CLEAR.
  - No req_valid: stay in IDLE, rr_ptr unchanged.
- **CLEAR:**
  - sw_rst=1 for exactly RST_CYCLES cycles.
  - At counter==0: set counter=COMPUTE_CYCLES-1, go to RUN.
  - Otherwise decrement counter.
- **RUN:**
  - sw_rst=0 for exactly COMPUTE_CYCLES cycles.
  - At counter==0, on that edge: capture the sw_aligned_* and sw_alignment_length inputs into res_*, set res_id=job_id, set res_valid=1, go to DONE.
- **DONE:**
  - sw_rst=1; the core is parked because results are already captured.
  - res_* held stable while res_valid=1 and res_ready=0.
  - On res_valid and res_ready: res_valid=0, go to IDLE; the earliest next grant is the following cycle.
- **sw_rst:** equals 1 in every state except RUN.
- **sw_ref_seq / sw_query_seq:** change only on an IDLE accept.
- **req_ready:** 0 in CLEAR, RUN and DONE. Requests are held off with no loss; requesters must hold req_valid and data until their ready bit is seen.
- **Latency:** accept edge at cycle T; res_valid first high at cycle T+1+RST_CYCLES+COMPUTE_CYCLES; 23 cycles with defaults.
- **Throughput:** one job in flight.
- **Simultaneous requests:** exactly one grant per accept; rr_ptr rotation guarantees no requester waits more than NUM_REQ-1 jobs.
- **req_valid dropped while not granted:** no effect.
- **Reset mid-operation:** immediate return to the reset values above. The in-flight job is discarded with no result; its requester must reissue.
- **sw_alignment_length:** passed through unmodified. No range checking; values > ALIGN_LEN are forwarded as-is.

Test Plan:
1. Single job: req_valid=4'b0001 with ref ACGTACGTACGTACG and query ACGTACGTAC, res_ready=1 -> req_ready=4'b0001 for one cycle; sw_rst high 2 cycles then low 20; res_valid at T+23 with res_id=0 and res_* equal to the core outputs sampled on the capture edge.
2. Round-robin: req_valid=4'b1111 held with res_ready=1 -> grant order 0,1,2,3,0; rr_ptr advances each accept.
3. Back-pressure: res_ready=0 for 10 cycles after res_valid -> res_* and res_id stable, busy=1, req_ready=0 throughout; the next grant comes the cycle after res_ready=1.
4. Async reset during RUN (5 cycles into compute) -> outputs immediately at reset values: sw_rst=1, res_valid=0, busy=0. The job is reissued and completes normally with res_id unchanged.
5. Fairness with gaps: requester 2 continuous, requester 1 asserting after the first grant -> grants 2,1,2; no requester is granted twice while another is waiting.
6. Parameter sweep: RST_CYCLES=1, COMPUTE_CYCLES=1 -> res_valid at T+3; sw_rst low exactly one cycle per job.
